aes_block_assembler: RTL and testbench
======================================

AES_BLOCK_ASSEMBLER -- requirements
Module: aes_block_assembler

Interface
REQ-001 The block SHALL have port hclk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-002 The block SHALL have port hrst, input, 1 bit: reset, asynchronous and active-low.
REQ-003 The block SHALL have port shift_en, input, 1 bit: a word from the AHB master is valid this cycle.
REQ-004 The block SHALL have port shiftin, input, 32 bits: the fetched data word (the master's shiftout).
REQ-005 The block SHALL have port end_block, input, 1 bit: the current word is the last word of the transfer.
REQ-006 The block SHALL have port blk_ready, input, 1 bit: the AES core accepts blk_data this cycle.
REQ-007 The block SHALL have port blk_data, output, 128 bits: the assembled block, word 0 in [127:96].
REQ-008 The block SHALL have port blk_valid, output, 1 bit: blk_data and blk_last are valid.
REQ-009 The block SHALL have port blk_last, output, 1 bit: the block was closed by end_block.
REQ-010 The block SHALL have port fetch_en, output, 1 bit: the master may fetch; it drives the master's enable.
REQ-011 The block SHALL have port overflow, output, 1 bit: sticky flag, a word was dropped.

Function
REQ-012 The block SHALL hold a 2-bit word counter wcnt (0..3) and a 96-bit partial register holding words 0..2.
REQ-013 An accepted word SHALL be written to slot wcnt; slot 0 is [127:96], slot 3 is [31:0].
REQ-014 A block SHALL complete when an accepted word has wcnt==3, or when an accepted word has end_block=1.
REQ-015 On completion the block SHALL push {partial words, current word, zero-padding of unfilled slots} plus a last flag into a 2-entry FIFO, and wcnt SHALL return to 0.
REQ-016 blk_last SHALL equal end_block of the completing word.
REQ-017 blk_valid SHALL be 1 whenever the FIFO is non-empty; blk_data and blk_last SHALL come from the FIFO head (registered, no combinational path from shiftin).
REQ-018 A pop SHALL occur when blk_valid && blk_ready; blk_data SHALL remain stable while blk_valid=1 and blk_ready=0.
REQ-019 Latency SHALL be: the completing word accepted at edge N, blk_valid=1 after edge N.
REQ-020 fetch_en SHALL equal (FIFO count < 2), registered.
REQ-021 A non-completing word SHALL always be accepted.
REQ-022 A completing word with the FIFO full and no pop in the same cycle SHALL be dropped: overflow set to 1, wcnt and the partial register unchanged.
REQ-023 A completing word with the FIFO full and a simultaneous pop SHALL be accepted; the FIFO count stays 2.
REQ-024 A simultaneous push and pop on a 1-entry FIFO SHALL leave the count at 1, with the new head being the pushed block.
REQ-025 FIFO pointers SHALL be 1-bit and wrap; the count SHALL be 2 bits.
REQ-026 overflow SHALL clear only on reset.
REQ-027 end_block with shift_en=0 SHALL be ignored.

Reset
REQ-028 While hrst=0, the block SHALL hold blk_valid=0, blk_last=0, blk_data=0, fetch_en=0, overflow=0, wcnt=0, partial=0, FIFO empty, and pointers 0.
REQ-029 fetch_en SHALL rise on the first hclk edge after hrst deasserts.
REQ-030 Reset asserted mid-block SHALL discard partial words and FIFO contents immediately (asynchronously).

Configuration
REQ-031 When ASSEMBLER_BSWAP_EN is defined, each accepted 32-bit word SHALL be byte-reversed before storage ({b0,b1,b2,b3}); without the macro, words SHALL be stored unmodified.

Verification
REQ-032 Four words 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF with blk_ready=1 -> blk_data=0x00112233_44556677_8899AABB_CCDDEEFF, blk_valid for 1 cycle, blk_last=0.
REQ-033 Two words 0xAAAAAAAA, 0xBBBBBBBB, the second with end_block=1 -> blk_data=0xAAAAAAAA_BBBBBBBB_00000000_00000000, blk_last=1, wcnt=0.
REQ-034 blk_ready=0 while 12 words are sent -> after 8 words fetch_en=0, the 12th word sets overflow=1, and the two buffered blocks are preserved and drained in order once blk_ready=1.
REQ-035 FIFO full, a completing word sent in the same cycle as blk_ready=1 -> no overflow, count stays 2, order preserved.
REQ-036 hrst pulsed low after 2 of 4 words -> all outputs reset; the next 4 words form a fresh block with no stale data.
REQ-037 With ASSEMBLER_BSWAP_EN defined, word 0x01020304 -> stored as 0x04030201 in [127:96].

Source files
------------

// File: rtl/aes_block_assembler.sv
// Packs 32-bit fetched words into 128-bit AES blocks behind a 2-entry output FIFO.
// Optional ASSEMBLER_BSWAP_EN byte-reverses each accepted word before it is stored.
module aes_asm_lane #(
    parameter int VEC_W = 32,
    parameter int CNT_W = 2,
    parameter int IDX   = 0
) (
    input  logic [CNT_W-1:0] wcnt,
    input  logic [VEC_W-1:0] word,
    input  logic [VEC_W-1:0] held,
    output logic [VEC_W-1:0] slot
);
    localparam logic [CNT_W-1:0] IDX_C = CNT_W'(IDX);

    // Slots past the write position are zero, which doubles as block padding.
    always_comb begin
        slot = '0;
        if (wcnt == IDX_C)
            slot = word;
        else if (wcnt > IDX_C)
            slot = held;
    end
endmodule

module aes_block_assembler #(
    parameter int NUM_LANES = 4,
    parameter int VEC_W     = 32
) (
    input  logic                       hclk,
    input  logic                       hrst,
    input  logic                       shift_en,
    input  logic [VEC_W-1:0]           shiftin,
    input  logic                       end_block,
    input  logic                       blk_ready,
    output logic [NUM_LANES*VEC_W-1:0] blk_data,
    output logic                       blk_valid,
    output logic                       blk_last,
    output logic                       fetch_en,
    output logic                       overflow
);
    localparam int                BLK_W = NUM_LANES * VEC_W;
    localparam int                CNT_W = $clog2(NUM_LANES);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(NUM_LANES - 1);

    typedef struct packed {
        logic             last;
        logic [BLK_W-1:0] data;
    } blk_t;

    logic [CNT_W-1:0]                  wcnt;
    logic [NUM_LANES-2:0][VEC_W-1:0]   partial;
    logic [NUM_LANES-1:0][VEC_W-1:0]   asm_slots;
    logic [VEC_W-1:0]                  word_in;

    blk_t       fifo_mem [2];
    logic       wr_ptr, rd_ptr;
    logic [1:0] count, count_nxt;

    logic pop, complete, drop, push, accept_mid;

`ifdef ASSEMBLER_BSWAP_EN
    assign word_in = {<<8{shiftin}};
`else
    assign word_in = shiftin;
`endif

    // Slot i lives at packed index NUM_LANES-1-i so slot 0 lands in the MSBs.
    genvar i;
    generate
        for (i = 0; i < NUM_LANES; i++) begin : g_lane
            logic [VEC_W-1:0] held;
            if (i < NUM_LANES - 1) begin : g_held
                assign held = partial[NUM_LANES-2-i];
            end else begin : g_none
                assign held = '0;
            end
            aes_asm_lane #(.VEC_W(VEC_W), .CNT_W(CNT_W), .IDX(i)) u_lane (
                .wcnt (wcnt),
                .word (word_in),
                .held (held),
                .slot (asm_slots[NUM_LANES-1-i])
            );
        end
    endgenerate

    assign blk_valid = (count != 2'd0);
    assign blk_data  = fifo_mem[rd_ptr].data;
    assign blk_last  = fifo_mem[rd_ptr].last;

    assign pop        = blk_valid & blk_ready;
    assign complete   = shift_en & ((wcnt == LAST) | end_block);
    assign drop       = complete & (count == 2'd2) & ~pop;
    assign push       = complete & ~drop;
    assign accept_mid = shift_en & ~complete;
    assign count_nxt  = count + {1'b0, push} - {1'b0, pop};

    always_ff @(posedge hclk or negedge hrst) begin
        if (!hrst) begin
            wcnt     <= '0;
            partial  <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= 2'd0;
            fetch_en <= 1'b0;
            overflow <= 1'b0;
            for (int k = 0; k < 2; k++) fifo_mem[k] <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr].last <= end_block;
                fifo_mem[wr_ptr].data <= asm_slots;
                wr_ptr  <= ~wr_ptr;
                wcnt    <= '0;
                partial <= '0;
            end else if (accept_mid) begin
                partial <= asm_slots[NUM_LANES-1:1];
                wcnt    <= wcnt + 1'b1;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            // A dropped word leaves wcnt and partial untouched.
            if (drop)
                overflow <= 1'b1;
            count    <= count_nxt;
            fetch_en <= (count_nxt < 2'd2);
        end
    end
endmodule

// File: tb/tb_aes_block_assembler.sv
// Randomized and directed checks of aes_block_assembler against a queue-based model.
module tb_aes_block_assembler;
    logic         hclk = 1'b0;
    logic         hrst = 1'b0;
    logic         shift_en = 1'b0;
    logic [31:0]  shiftin = '0;
    logic         end_block = 1'b0;
    logic         blk_ready = 1'b0;
    logic [127:0] blk_data;
    logic         blk_valid, blk_last, fetch_en, overflow;

    aes_block_assembler dut (
        .hclk(hclk), .hrst(hrst), .shift_en(shift_en), .shiftin(shiftin),
        .end_block(end_block), .blk_ready(blk_ready), .blk_data(blk_data),
        .blk_valid(blk_valid), .blk_last(blk_last), .fetch_en(fetch_en),
        .overflow(overflow)
    );

    always #5 hclk = ~hclk;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0]  m_words[$];
    logic [128:0] m_fifo[$];
    bit           m_ovf;
    bit           m_run;

    function automatic logic [31:0] bsw(input logic [31:0] w);
`ifdef ASSEMBLER_BSWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_words.delete();
        m_fifo.delete();
        m_ovf = 0;
        m_run = 0;
    endtask

    // Applies one clock edge of the block's rules to the queues.
    task automatic model_step();
        bit           pop, comp, do_push;
        logic [127:0] b;
        pop     = (m_fifo.size() != 0) && blk_ready;
        do_push = 0;
        b       = '0;
        if (shift_en) begin
            comp = (m_words.size() == 3) || end_block;
            if (comp && m_fifo.size() == 2 && !pop) begin
                m_ovf = 1;
            end else if (comp) begin
                m_words.push_back(bsw(shiftin));
                for (int i = 0; i < m_words.size(); i++)
                    b[127 - 32*i -: 32] = m_words[i];
                m_words.delete();
                do_push = 1;
            end else begin
                m_words.push_back(bsw(shiftin));
            end
        end
        if (pop) void'(m_fifo.pop_front());
        if (do_push) m_fifo.push_back({end_block, b});
        m_run = 1;
    endtask

    task automatic check_outputs();
        chk("blk_valid", blk_valid, m_fifo.size() != 0);
        if (m_fifo.size() != 0) begin
            chk("blk_data", blk_data, m_fifo[0][127:0]);
            chk("blk_last", blk_last, m_fifo[0][128]);
        end
        chk("fetch_en", fetch_en, m_run && m_fifo.size() < 2);
        chk("overflow", overflow, m_ovf);
        chk("wcnt", dut.wcnt, m_words.size());
    endtask

    task automatic check_reset();
        chk("rst_valid", blk_valid, 0);
        chk("rst_last", blk_last, 0);
        chk("rst_data", blk_data, 0);
        chk("rst_fetch", fetch_en, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_wcnt", dut.wcnt, 0);
    endtask

    task automatic cycle(input bit se, input logic [31:0] w, input bit eb, input bit rdy);
        shift_en  = se;
        shiftin   = w;
        end_block = eb;
        blk_ready = rdy;
        @(posedge hclk);
        model_step();
        #1;
        check_outputs();
    endtask

    task automatic release_reset();
        repeat (2) @(posedge hclk);
        @(negedge hclk);
        hrst = 1'b1;
        #1;
        chk("fetch_pre_edge", fetch_en, 0);
    endtask

    task automatic do_reset();
        hrst = 1'b0;
        shift_en = 0; end_block = 0; blk_ready = 0; shiftin = '0;
        #1;
        model_clear();
        check_reset();
        release_reset();
    endtask

    initial begin
        do_reset();

        // Four plain words, sink always ready
        cycle(1, 32'h00112233, 0, 1);
        cycle(1, 32'h44556677, 0, 1);
        cycle(1, 32'h8899AABB, 0, 1);
        cycle(1, 32'hCCDDEEFF, 0, 1);
        chk("four_word_data", blk_data,
            {bsw(32'h00112233), bsw(32'h44556677), bsw(32'h8899AABB), bsw(32'hCCDDEEFF)});
        chk("four_word_last", blk_last, 0);
        cycle(0, 32'h0, 0, 1);
        chk("four_word_one_cycle", blk_valid, 0);

        // Short block closed by end_block
        cycle(1, 32'hAAAAAAAA, 0, 0);
        cycle(1, 32'hBBBBBBBB, 1, 0);
        chk("short_data", blk_data, {bsw(32'hAAAAAAAA), bsw(32'hBBBBBBBB), 64'h0});
        chk("short_last", blk_last, 1);
        chk("short_wcnt", dut.wcnt, 0);
        cycle(0, 32'h0, 1, 1);
        cycle(0, 32'h0, 1, 1);   // end_block without shift_en is ignored

        // Backpressure: 12 words with no ready
        for (int i = 0; i < 12; i++) begin
            cycle(1, 32'h1000_0000 + i, 0, 0);
            if (i == 7) chk("bp_fetch_low", fetch_en, 0);
        end
        chk("bp_overflow", overflow, 1);
        chk("bp_head", blk_data, {bsw(32'h10000000), bsw(32'h10000001),
                                  bsw(32'h10000002), bsw(32'h10000003)});
        repeat (3) cycle(0, 32'h0, 0, 1);
        cycle(1, 32'h2000_0000, 0, 1);   // completes the held 3-word partial

        do_reset();

        // Full FIFO with a completing word on a pop cycle
        for (int i = 0; i < 11; i++) cycle(1, 32'h3000_0000 + i, 0, 0);
        cycle(1, 32'h3000_000B, 0, 1);
        chk("pushpop_ovf", overflow, 0);
        chk("pushpop_count", dut.count, 2);
        repeat (3) cycle(0, 32'h0, 0, 1);

        // Reset pulse mid-block, then a fresh block
        cycle(1, 32'hDEADBEEF, 0, 0);
        cycle(1, 32'hCAFEF00D, 0, 0);
        #2;
        hrst = 1'b0;
        #1;
        model_clear();
        check_reset();
        shift_en = 0; end_block = 0; blk_ready = 0;
        release_reset();
        cycle(1, 32'h01020304, 0, 1);
        cycle(1, 32'h05060708, 0, 1);
        cycle(1, 32'h090A0B0C, 0, 1);
        cycle(1, 32'h0D0E0F10, 0, 1);
        chk("fresh_data", blk_data, {bsw(32'h01020304), bsw(32'h05060708),
                                     bsw(32'h090A0B0C), bsw(32'h0D0E0F10)});
`ifdef ASSEMBLER_BSWAP_EN
        chk("bswap_word0", blk_data[127:96], 32'h04030201);
`endif

        // Random traffic
        for (int n = 0; n < 2000; n++) begin
            bit se, eb, rdy;
            se  = ($urandom_range(0, 9) < 7);
            eb  = ($urandom_range(0, 9) < 2);
            rdy = ($urandom_range(0, 9) < 5);
            cycle(se, $urandom, eb, rdy);
            if (n == 1000) do_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
